sr_latch_driver: RTL and testbench

//  Clocked driver that writes a gated NOR SR latch with active-low s/r/en.
//  It turns a one-bit write request (valid/ready) into a timed set/clear sequence.

---
 rtl/sr_latch_driver.sv | 196 +++++++++++++++++++
 tb/tb_sr_latch_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Timed setup/gate-pulse/hold write sequencer for an asynchronous gated NOR SR latch.
// Optional feature macro READBACK_CHECK_EN: q/qn readback with retry and err reporting.
module sr_latch_driver #(
    parameter int SETUP     = 1,
    parameter int PULSE_W   = 4,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_val,
    output logic req_ready,
    output logic done,
    output logic err,
    output logic s_n,
    output logic r_n,
    output logic en_n,
    input  logic q,
    input  logic qn
);

    localparam int MAX_A   = (SETUP > PULSE_W) ? SETUP : PULSE_W;
    localparam int MAX_CNT = (MAX_A > SETTLE) ? MAX_A : SETTLE;
    localparam int CW      = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_val;
    logic          r_s_n;
    logic          r_r_n;
    logic          r_en_n;
    logic          r_ready;
    logic          r_done;
    logic          r_err;

    logic [2:0]    w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_val_next;
    logic          w_done_next;
    logic          w_err_next;
    logic          w_drive_next;
    logic          w_accept;

    assign w_accept = req_valid & r_ready;

`ifdef READBACK_CHECK_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [CW-1:0] SETTLE_LD  = CW'(SETTLE - 1);
    localparam logic [2:0]    S_CHECK    = 3'd4;

    logic [RW-1:0] r_retry;
    logic [RW-1:0] w_retry_next;
    logic          r_q_meta;
    logic          r_q_sync;
    logic          r_qn_meta;
    logic          r_qn_sync;
    logic          w_pass;

    // q == qn (both 0 after an illegal overlap, or both 1) can never satisfy this
    assign w_pass = (r_q_sync == r_val) && (r_qn_sync == ~r_val);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q_meta  <= 1'b0;
            r_q_sync  <= 1'b0;
            r_qn_meta <= 1'b0;
            r_qn_sync <= 1'b0;
            r_retry   <= '0;
        end else begin
            r_q_meta  <= q;
            r_q_sync  <= r_q_meta;
            r_qn_meta <= qn;
            r_qn_sync <= r_qn_meta;
            r_retry   <= w_retry_next;
        end
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, q, qn, MAX_RETRY[0]};
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_val_next   = r_val;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
`ifdef READBACK_CHECK_EN
        w_retry_next = r_retry;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_SETUP;
                    w_cnt_next   = SETUP_LD;
                    w_val_next   = req_val;
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_next = S_PULSE;
                    w_cnt_next   = PULSE_LD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_next = S_HOLD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
`ifdef READBACK_CHECK_EN
                w_state_next = S_CHECK;
                w_cnt_next   = SETTLE_LD;
`else
                w_state_next = S_IDLE;
                w_done_next  = 1'b1;
`endif
            end
`ifdef READBACK_CHECK_EN
            S_CHECK: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else if (w_pass) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                    w_retry_next = '0;
                end else if (r_retry == RETRY_LAST) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                    w_err_next   = 1'b1;
                    w_retry_next = '0;
                end else begin
                    // rewrite the same value; requester sees nothing until the final outcome
                    w_state_next = S_SETUP;
                    w_cnt_next   = SETUP_LD;
                    w_retry_next = r_retry + RW'(1);
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every latch pin comes straight off a flop
    assign w_drive_next = (w_state_next == S_SETUP) ||
                          (w_state_next == S_PULSE) ||
                          (w_state_next == S_HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_val   <= 1'b0;
            r_s_n   <= 1'b1;
            r_r_n   <= 1'b1;
            r_en_n  <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_val   <= w_val_next;
            r_s_n   <= ~(w_drive_next & w_val_next);
            r_r_n   <= ~(w_drive_next & ~w_val_next);
            r_en_n  <= ~(w_state_next == S_PULSE);
            r_ready <= (w_state_next == S_IDLE);
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    assign req_ready = r_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign s_n       = r_s_n;
    assign r_n       = r_r_n;
    assign en_n      = r_en_n;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: gated NOR latch model, per-cycle waveform model and done scoreboard.
module tb_sr_latch_driver;

    localparam int SETUP     = 1;
    localparam int PULSE_W   = 4;
    localparam int SETTLE    = 2;
    localparam int MAX_RETRY = 2;
`ifdef READBACK_CHECK_EN
    localparam bit RB     = 1'b1;
    localparam int PERIOD = SETUP + PULSE_W + 1 + SETTLE;
`else
    localparam bit RB     = 1'b0;
    localparam int PERIOD = SETUP + PULSE_W + 1;
`endif

    typedef struct {
        bit val;
        bit stuck;
        bit chain;
        bit chain_val;
        bit imm;
    } vec_t;

    typedef struct {
        bit val;
        int attempts;
        bit err;
        bit q;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_val = 1'b0;
    logic req_ready, done, err, s_n, r_n, en_n;
    logic m_q = 1'b0;
    logic m_qn = 1'b1;
    bit   m_stuck = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    sr_latch_driver #(
        .SETUP(SETUP), .PULSE_W(PULSE_W), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_val(req_val),
        .req_ready(req_ready), .done(done), .err(err),
        .s_n(s_n), .r_n(r_n), .en_n(en_n), .q(m_q), .qn(m_qn)
    );

    function automatic logic [1:0] latch_next(input logic s, input logic r, input logic en,
                                              input logic cq, input logic cqn, input bit stuck);
        logic [1:0] nx;
        nx = {cq, cqn};
        if (!en) begin
            if (!s && !r)  nx = 2'b00;
            else if (!s)   nx = 2'b10;
            else if (!r)   nx = 2'b01;
        end
        if (stuck) nx[1] = 1'b0;
        return nx;
    endfunction

    // gated NOR latch seen through one cycle of delay
    always @(posedge clk) begin
        {m_q, m_qn} <= latch_next(s_n, r_n, en_n, m_q, m_qn, m_stuck);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    logic p_s_n = 1'b1;
    logic p_r_n = 1'b1;
    logic p_en_n = 1'b1;
    always @(negedge clk) begin
        if (rst_n) begin
            check("no_sr_overlap", {31'd0, s_n | r_n}, 32'd1);
            if (!p_en_n || !en_n)
                check("sr_stable_gate_open", {30'd0, s_n, r_n}, {30'd0, p_s_n, p_r_n});
        end
        p_s_n  = s_n;
        p_r_n  = r_n;
        p_en_n = en_n;
    end

    task automatic run_txn(input vec_t v);
        exp_t e;
        exp_t got;
        int   waited;
        int   done_idx;
        int   o;
        bit   seen;
        bit   drv;
        bit   gate;
        req_valid = 1'b1;
        req_val   = v.val;
        m_stuck   = v.stuck;
        waited    = 0;
        while (!req_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("accept_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (v.imm) check("b2b_accept_wait", waited, 0);
        e.val      = v.val;
        e.attempts = (RB && v.stuck) ? MAX_RETRY + 1 : 1;
        e.err      = RB && v.stuck;
        e.q        = v.stuck ? 1'b0 : v.val;
        done_idx   = e.attempts * PERIOD + 1;
        sb.push_back(e);
        @(posedge clk);
        seen = 1'b0;
        for (int idx = 1; idx <= done_idx + 4 && !seen; idx++) begin
            @(negedge clk);
            if (idx == 1) req_valid = 1'b0;
            if (idx <= done_idx) begin
                if (idx == done_idx) begin
                    drv = 1'b0; gate = 1'b0;
                end else begin
                    o    = (idx - 1) % PERIOD;
                    drv  = (o < SETUP + PULSE_W + 1);
                    gate = (o >= SETUP) && (o < SETUP + PULSE_W);
                end
                check($sformatf("s_n@%0d", idx),   {31'd0, s_n},  {31'd0, ~(drv & v.val)});
                check($sformatf("r_n@%0d", idx),   {31'd0, r_n},  {31'd0, ~(drv & ~v.val)});
                check($sformatf("en_n@%0d", idx),  {31'd0, en_n}, {31'd0, ~gate});
                check($sformatf("ready@%0d", idx), {31'd0, req_ready}, {31'd0, idx == done_idx});
                check($sformatf("done@%0d", idx),  {31'd0, done}, {31'd0, idx == done_idx});
            end
            if (done) begin
                got = sb.pop_front();
                check("done_index", idx, got.attempts * PERIOD + 1);
                check("err", {31'd0, err}, {31'd0, got.err});
                check("latch_q", {31'd0, m_q}, {31'd0, got.q});
                seen = 1'b1;
                m_stuck = 1'b0;
                if (v.chain) begin
                    req_valid = 1'b1;
                    req_val   = v.chain_val;
                end
            end
        end
        if (!seen) begin
            check("done_seen", {31'd0, done}, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        $display("[TB] txn val=%0d stuck=%0d attempts=%0d done_seen=%0d", v.val, v.stuck, e.attempts, seen);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        vecs.push_back('{val: 1'b1, stuck: 1'b0, chain: 1'b0, chain_val: 1'b0, imm: 1'b0});
        vecs.push_back('{val: 1'b0, stuck: 1'b0, chain: 1'b0, chain_val: 1'b0, imm: 1'b0});
        vecs.push_back('{val: 1'b1, stuck: 1'b0, chain: 1'b1, chain_val: 1'b0, imm: 1'b0});
        vecs.push_back('{val: 1'b0, stuck: 1'b0, chain: 1'b0, chain_val: 1'b0, imm: 1'b1});
        vecs.push_back('{val: 1'b0, stuck: 1'b0, chain: 1'b0, chain_val: 1'b0, imm: 1'b0});
        vecs.push_back('{val: 1'b1, stuck: 1'b0, chain: 1'b0, chain_val: 1'b0, imm: 1'b0});
`ifdef READBACK_CHECK_EN
        vecs.push_back('{val: 1'b1, stuck: 1'b1, chain: 1'b0, chain_val: 1'b0, imm: 1'b0});
        vecs.push_back('{val: 1'b0, stuck: 1'b0, chain: 1'b0, chain_val: 1'b0, imm: 1'b0});
        vecs.push_back('{val: 1'b1, stuck: 1'b0, chain: 1'b0, chain_val: 1'b0, imm: 1'b0});
`endif

        // power-on reset state
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_s_n", {31'd0, s_n}, 32'd1);
        check("rst_r_n", {31'd0, r_n}, 32'd1);
        check("rst_en_n", {31'd0, en_n}, 32'd1);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i]);

        // reset asserted in the middle of the gate pulse
        @(negedge clk);
        req_valid = 1'b1;
        req_val   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_pulse_en_n", {31'd0, en_n}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_s_n", {31'd0, s_n}, 32'd1);
        check("midrst_r_n", {31'd0, r_n}, 32'd1);
        check("midrst_en_n", {31'd0, en_n}, 32'd1);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        run_txn('{val: 1'b0, stuck: 1'b0, chain: 1'b0, chain_val: 1'b0, imm: 1'b0});
        run_txn('{val: 1'b1, stuck: 1'b0, chain: 1'b0, chain_val: 1'b0, imm: 1'b0});

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
